// File: rtl/bus_arbiter8.sv
// rtl/bus_arbiter8.sv - eight-way round-robin arbiter with completion handover
// Optional watchdog that revokes stuck grants: define ARBITER_TIMEOUT_EN.
module bus_arbiter8 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [7:0] i_Request,
    input  logic       i_Done,
    output logic [7:0] o_Grant,
    output logic [2:0] o_Select,
    output logic       o_Valid,
    output logic       o_Timeout
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       timeout_q, timeout_d;
    logic [2:0] arb_ptr;
    logic       win_found;
    logic [2:0] win_idx;
    logic       release_now;
    logic       expire;

    // First set request at or above start, wrapping modulo 8.
    function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!res[3] && req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef ARBITER_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
`else
    wire unused_timeout_cfg = ^TO_LIM;
`endif

    // While busy, sel_q is the current winner, so the next scan starts just past it.
    assign arb_ptr = (state_q == BUSY) ? sel_q + 3'd1 : ptr_q;
    assign {win_found, win_idx} = pick(i_Request, arb_ptr);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        timeout_d   = 1'b0;
        expire      = 1'b0;
        release_now = 1'b0;
`ifdef ARBITER_TIMEOUT_EN
        wdog_d      = wdog_q;
        if (state_q == BUSY && !i_Done) begin
            wdog_d = wdog_q + 16'd1;
            expire = (wdog_q + 16'd1 == TO_LIM);
        end
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = 8'd1 << win_idx;
                    sel_d   = win_idx;
`ifdef ARBITER_TIMEOUT_EN
                    wdog_d  = 16'd0;
`endif
                end
            end
            BUSY: begin
                release_now = i_Done || expire;
                if (release_now) begin
                    ptr_d     = arb_ptr;
                    timeout_d = expire;
                    if (win_found) begin
                        grant_d = 8'd1 << win_idx;
                        sel_d   = win_idx;
`ifdef ARBITER_TIMEOUT_EN
                        wdog_d  = 16'd0;
`endif
                    end else begin
                        state_d = IDLE;
                        grant_d = 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            grant_q   <= 8'd0;
            sel_q     <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ARBITER_TIMEOUT_EN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) wdog_q <= 16'd0;
        else         wdog_q <= wdog_d;
    end
`endif

    assign o_Grant   = grant_q;
    assign o_Select  = sel_q;
    assign o_Valid   = (state_q == BUSY);
    assign o_Timeout = timeout_q;

endmodule
